// File: rtl/fwft_fifo_if.sv
// rtl/fwft_fifo_if.sv - producer/consumer handshake bundle for fwft_fifo.
interface fwft_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  rd;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;

  modport master (
    output wr,
    output wr_data,
    input  full,
    output rd,
    input  rd_data,
    input  empty
  );

  modport slave (
    input  wr,
    input  wr_data,
    output full,
    input  rd,
    output rd_data,
    output empty
  );
endinterface

// File: rtl/fwft_fifo.sv
// rtl/fwft_fifo.sv - single-clock first-word-fall-through FIFO on a register array.
module fwft_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  fwft_fifo_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_w, full_w, wr_acc, rd_acc;

  always_comb begin
    empty_w  = (count_q == '0);
    full_w   = (count_q == DEPTH_C);
    // A write while full is still accepted when the same edge pops the head.
    wr_acc   = bus.wr & (~full_w | bus.rd);
    rd_acc   = bus.rd & ~empty_w;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + (ADDR_WIDTH + 1)'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.empty   = empty_w;
  assign bus.full    = full_w;
  assign bus.rd_data = empty_w ? '0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_fwft_fifo.sv
// tb/tb_fwft_fifo.sv - scoreboard bench for fwft_fifo with directed and random traffic.
module tb_fwft_fifo;
  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 2 ** AW;

  typedef struct {
    int            occ;
    logic [DW-1:0] head;
  } snap_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_rd_q[$];
  snap_t         exp_snap_q[$];
  snap_t         snap;
  logic [DW-1:0] exp_word;

  fwft_fifo_if #(.DATA_WIDTH(DW)) bus ();

  fwft_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model advances by queue rules.
  task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, input logic do_rst);
    int  sz;
    logic wacc, racc;
    @(posedge clk);
    #1;
    rst         = do_rst;
    bus.wr      = w;
    bus.rd      = r;
    bus.wr_data = d;
    if (do_rst) begin
      model_q.delete();
    end else begin
      sz = model_q.size();
      exp_snap_q.push_back('{occ: sz, head: (sz > 0) ? model_q[0] : '0});
      racc = r && (sz > 0);
      wacc = w && ((sz < DEPTH) || r);
      if (racc) exp_rd_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(d);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && exp_snap_q.size() > 0) begin
      snap = exp_snap_q.pop_front();
      chk("empty", DW'(bus.empty), DW'(snap.occ == 0));
      chk("full", DW'(bus.full), DW'(snap.occ == DEPTH));
      chk("rd_data_head", bus.rd_data, snap.head);
      if (bus.rd === 1'b1 && bus.empty === 1'b0) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%08h expected no pop at %0t", bus.rd_data, $time);
        end else begin
          exp_word = exp_rd_q.pop_front();
          chk("pop_data", bus.rd_data, exp_word);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] word_list [6];
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.wr_data = '0;
    word_list   = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF};

    drive(1'b1, 1'b1, 32'h1111_2222, 1'b1);
    drive(1'b1, 1'b1, 32'h3333_4444, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);

    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, word_list[i], 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, word_list[i], 1'b0);
    drive(1'b1, 1'b1, 32'h0000_00A1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, '0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'h100 + DW'(i), 1'b0);
      drive(1'b0, 1'b1, '0, 1'b0);
    end
    drive(1'b1, 1'b1, 32'h5, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
            $urandom(), ($urandom_range(0, 99) == 0));
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i <= DEPTH; i++) drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);

    @(negedge clk);
    #1;
    chk("snap_queue_drained", DW'(exp_snap_q.size()), '0);
    chk("pop_queue_drained", DW'(exp_rd_q.size()), '0);
    chk("model_empty_at_end", DW'(model_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
